// File: rtl/rv32_mod_fetch.sv
// Instruction fetch front end: owns the PC, issues imem req/gnt/rvalid reads, buffers words for decode.
// Latency: rvalid in cycle N -> instr_valid in cycle N+1 at the earliest; misalign_err is one cycle after branch_taken.
// Backpressure: instr_ready low fills the DEPTH-entry buffer; imem_req drops once outstanding+buffered reaches DEPTH.
//
// Ports: clk/rstn (sync active-low reset); imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata (memory side);
//        branch_taken/branch_target (redirect); instr_valid/instr_ready/instr/instr_pc (decode side);
//        misalign_err (one-cycle pulse for an unaligned redirect target).
module rv32_mod_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);
    localparam int             CW       = $clog2(DEPTH + 1);
    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_exp_pc;       // address of the next response that will be kept
    logic [CW-1:0] r_out;          // requests granted but not yet answered
    logic [CW-1:0] r_disc;         // responses still to be dropped after a redirect
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic          r_mis;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];

    logic [CW:0]   w_inflight;
    logic          w_gnt;
    logic          w_rv;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_target;
    logic [CW-1:0] w_out_nxt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Credit counts buffered words too; a pop this cycle does not free a slot until next cycle.
    assign w_inflight = {1'b0, r_out} + {1'b0, r_cnt};
    assign imem_req   = rstn && (w_inflight < {1'b0, DEPTH_C});
    assign imem_addr  = r_pc;

    assign w_gnt    = imem_req && imem_gnt;
    assign w_rv     = imem_rvalid && (r_out != '0);
    assign w_drop   = w_rv && (r_disc != '0);
    // A word arriving in the redirect cycle belongs to the old stream and is flushed too.
    assign w_push   = w_rv && !w_drop && !branch_taken;
    assign w_pop    = instr_valid && instr_ready;
    assign w_target = {branch_target[31:2], 2'b00};

    assign instr_valid  = (r_cnt != '0);
    assign instr        = r_mem_instr[r_rp];
    assign instr_pc     = r_mem_pc[r_rp];
    assign misalign_err = r_mis;

    always_comb begin
        w_out_nxt = r_out;
        if (w_gnt && !w_rv) begin
            w_out_nxt = r_out + CW'(1);
        end else if (!w_gnt && w_rv) begin
            w_out_nxt = r_out - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc     <= RESET_PC;
            r_exp_pc <= RESET_PC;
            r_out    <= '0;
            r_disc   <= '0;
            r_cnt    <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_mis    <= 1'b0;
        end else begin
            assert (!(w_push && !w_pop && (r_cnt == DEPTH_C)));
            r_out <= w_out_nxt;
            r_mis <= branch_taken && (branch_target[1:0] != 2'b00);
            if (branch_taken) begin
                r_pc     <= w_target;
                r_exp_pc <= w_target;
                // Everything still in flight (including a grant this cycle) is stale.
                r_disc   <= w_out_nxt;
                r_cnt    <= '0;
                r_wp     <= '0;
                r_rp     <= '0;
            end else begin
                if (w_gnt) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_drop) begin
                    r_disc <= r_disc - CW'(1);
                end
                if (w_push) begin
                    r_exp_pc <= r_exp_pc + 32'd4;
                    r_wp     <= f_inc(r_wp);
                end
                if (w_pop) begin
                    r_rp <= f_inc(r_rp);
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    // Storage needs no reset; validity is tracked by r_cnt.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wp] <= imem_rdata;
            r_mem_pc[r_wp]    <= r_exp_pc;
        end
    end

endmodule
